// File: rtl/rxdsp_spectrum_reader_if.sv
// Bundle of the FFT log-power write port and the AXI-stream output of the spectrum reader.
// "master" is the side that produces spectrum writes and consumes the stream.
interface rxdsp_spectrum_reader_if #(
    parameter int BUFFER_SIZE_ADDR = 16
);
    logic [63:0]                 dsp_data;
    logic                        dsp_valid;
    logic                        dsp_last;
    logic [7:0]                  dsp_keep;
    logic [BUFFER_SIZE_ADDR-4:0] dsp_waddr;

    logic [63:0]                 m_axis_tdata;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        m_axis_tlast;

    modport master (
        output dsp_data, dsp_valid, dsp_last, dsp_keep, dsp_waddr, m_axis_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );

    modport slave (
        input  dsp_data, dsp_valid, dsp_last, dsp_keep, dsp_waddr, m_axis_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast
    );
endinterface

// File: rtl/rxdsp_spectrum_reader.sv
// Ping-pong capture of FFT log-power buffers into two byte-enabled RAM banks,
// replayed in commit order on an AXI-stream master; buffers with no free bank are dropped.
module rxdsp_spectrum_reader #(
    parameter int BUFFER_SIZE_ADDR = 16,
    parameter int OVF_CNT_BITS     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [BUFFER_SIZE_ADDR-1:0] cfg_bsz,
    rxdsp_spectrum_reader_if.slave      bus,
    output logic [OVF_CNT_BITS-1:0]     stat_ovf_cnt,
    output logic [1:0]                  stat_full
);
    localparam int WA    = BUFFER_SIZE_ADDR - 3;
    localparam int DEPTH = 1 << WA;

    typedef enum logic {W_WRITE, W_DROP}  wstate_t;
    typedef enum logic {R_IDLE, R_STREAM} rstate_t;

    // write side
    wstate_t                 wstate_reg;
    logic                    wbank_reg;
    logic [1:0]              full_reg;
    logic [OVF_CNT_BITS-1:0] ovf_reg;
    logic [1:0]              wr_en;
    logic                    commit;

    // read side
    rstate_t                 rstate_reg;
    logic                    rbank_reg;
    logic [WA-1:0]           n_last_reg;
    logic [WA-1:0]           rd_addr_reg;
    logic                    issue_done_reg;
    logic                    rd_pend_reg;
    logic                    rd_last_reg;
    logic                    out_valid_reg;
    logic [63:0]             out_data_reg;
    logic                    out_last_reg;
    logic                    sk_valid_reg;
    logic [63:0]             sk_data_reg;
    logic                    sk_last_reg;

    logic [63:0]             rd_q [2];
    logic [63:0]             rd_data;
    logic [WA-1:0]           cfg_n_last;
    logic [WA-1:0]           cur_n_last;
    logic [WA-1:0]           raddr;
    logic [1:0]              occ;
    logic                    pop;
    logic                    room;
    logic                    issue;
    logic                    issue_last;
    logic                    free;
    logic                    unused_cfg_bits;

    assign cfg_n_last      = cfg_bsz[BUFFER_SIZE_ADDR-1:3];
    assign unused_cfg_bits = ^cfg_bsz[2:0];

    assign commit = (wstate_reg == W_WRITE) && bus.dsp_valid && bus.dsp_last;

    // Two banks, each with byte-lane write enables and a registered read port.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic [63:0] mem [DEPTH];
            logic [63:0] q_reg;

            assign wr_en[gi] = (wstate_reg == W_WRITE) && bus.dsp_valid && (wbank_reg == 1'(gi));

            always_ff @(posedge clk) begin
                for (int b = 0; b < 8; b++) begin
                    if (wr_en[gi] && bus.dsp_keep[b]) begin
                        mem[bus.dsp_waddr][8*b +: 8] <= bus.dsp_data[8*b +: 8];
                    end
                end
                q_reg <= mem[raddr];
            end

            assign rd_q[gi] = q_reg;
        end
    endgenerate

    // Write FSM: the writer only ever hops to the other bank, and only when it is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_reg <= W_WRITE;
            wbank_reg  <= 1'b0;
            ovf_reg    <= '0;
        end else begin
            case (wstate_reg)
                W_WRITE: begin
                    if (bus.dsp_valid && bus.dsp_last) begin
                        if (!full_reg[wbank_reg ^ 1'b1]) begin
                            wbank_reg <= wbank_reg ^ 1'b1;
                        end else begin
                            wstate_reg <= W_DROP;
                        end
                    end
                end
                W_DROP: begin
                    if (bus.dsp_valid && bus.dsp_last) begin
                        if (ovf_reg != {OVF_CNT_BITS{1'b1}}) begin
                            ovf_reg <= ovf_reg + 1'b1;
                        end
                        if (!full_reg[wbank_reg ^ 1'b1]) begin
                            wbank_reg  <= wbank_reg ^ 1'b1;
                            wstate_reg <= W_WRITE;
                        end
                    end
                end
                default: wstate_reg <= W_WRITE;
            endcase
        end
    end

    // Commit and free never target the same bank, so both may land in one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            full_reg <= 2'b00;
        end else begin
            if (commit) begin
                full_reg[wbank_reg] <= 1'b1;
            end
            if (free) begin
                full_reg[rbank_reg] <= 1'b0;
            end
        end
    end

    // Credit check: a read issued now lands next cycle and must find a slot
    // in output register + skid even if the consumer stalls.
    assign occ   = {1'b0, out_valid_reg} + {1'b0, sk_valid_reg} + {1'b0, rd_pend_reg};
    assign pop   = out_valid_reg && bus.m_axis_tready;
    assign room  = (occ - {1'b0, pop}) <= 2'd1;
    assign free  = pop && out_last_reg;

    assign raddr      = (rstate_reg == R_IDLE) ? '0 : rd_addr_reg;
    assign cur_n_last = (rstate_reg == R_IDLE) ? cfg_n_last : n_last_reg;
    assign issue_last = (raddr == cur_n_last);
    assign issue      = room && (((rstate_reg == R_IDLE) && full_reg[rbank_reg]) ||
                                 ((rstate_reg == R_STREAM) && !issue_done_reg));
    assign rd_data    = rd_q[rbank_reg];

    // Read FSM plus output register / skid buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_reg     <= R_IDLE;
            rbank_reg      <= 1'b0;
            n_last_reg     <= '0;
            rd_addr_reg    <= '0;
            issue_done_reg <= 1'b0;
            rd_pend_reg    <= 1'b0;
            rd_last_reg    <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            sk_valid_reg   <= 1'b0;
            sk_last_reg    <= 1'b0;
        end else begin
            rd_pend_reg <= issue;
            rd_last_reg <= issue_last;

            case (rstate_reg)
                R_IDLE: begin
                    if (issue) begin
                        n_last_reg     <= cfg_n_last;
                        rd_addr_reg    <= WA'(1);
                        issue_done_reg <= issue_last;
                        rstate_reg     <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (issue) begin
                        rd_addr_reg    <= rd_addr_reg + 1'b1;
                        issue_done_reg <= issue_last;
                    end
                    if (free) begin
                        rstate_reg <= R_IDLE;
                        rbank_reg  <= rbank_reg ^ 1'b1;
                    end
                end
                default: rstate_reg <= R_IDLE;
            endcase

            if (!out_valid_reg || bus.m_axis_tready) begin
                if (sk_valid_reg) begin
                    out_data_reg  <= sk_data_reg;
                    out_last_reg  <= sk_last_reg;
                    out_valid_reg <= 1'b1;
                    sk_valid_reg  <= rd_pend_reg;
                    sk_data_reg   <= rd_data;
                    sk_last_reg   <= rd_last_reg;
                end else if (rd_pend_reg) begin
                    out_data_reg  <= rd_data;
                    out_last_reg  <= rd_last_reg;
                    out_valid_reg <= 1'b1;
                end else begin
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                end
            end else if (rd_pend_reg) begin
                sk_data_reg  <= rd_data;
                sk_last_reg  <= rd_last_reg;
                sk_valid_reg <= 1'b1;
            end
        end
    end

    assign bus.m_axis_tdata  = out_data_reg;
    assign bus.m_axis_tvalid = out_valid_reg;
    assign bus.m_axis_tlast  = out_last_reg;
    assign stat_ovf_cnt      = ovf_reg;
    assign stat_full         = full_reg;
endmodule
